gshare_bpred: RTL and testbench
===============================

Name: gshare_bpred

Overview:
- Fetch-stage direction and target predictor for the LoongArch32 pipeline; the successor to the single 2-bit-history predictor.
- Holds a PC-indexed table of 2^IDX_W 2-bit saturating counters, optionally XOR-hashed with a speculative global history register (GHR).
- Produces the predicted next PC combinationally from pc/inst.
- Is trained and repaired from the EX stage.
- After reset it runs a multi-cycle table-initialisation sweep before it predicts.

Parameters:
- IDX_W, 6, PHT index width; table depth = 2^IDX_W (legal range 2..10).
- HIST_W, 4, GHR width (1..IDX_W).
- USE_GHR, 1, 1 = gshare index (pc hash XOR GHR); 0 = pure PC-indexed bimodal, GHR frozen at 0.
- INIT_CTR, 2'b01, counter value written to every entry during the init sweep.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- fetch_fire  in  1  pc/inst accepted by IF this cycle; commits the speculative GHR update.
- pc  in  32  fetch PC.
- inst  in  32  fetched instruction.
- pre_pc  out  32  predicted next PC.
- pred_taken  out  1  prediction is taken.
- pred_idx  out  IDX_W  PHT index used; carried down the pipe.
- pred_ghr  out  HIST_W  GHR value before this fetch; carried down the pipe.
- upd_valid  in  1  EX resolved a conditional branch.
- upd_idx  in  IDX_W  index carried from fetch.
- upd_ghr  in  HIST_W  GHR carried from fetch.
- upd_taken  in  1  actual direction.
- upd_mispredict  in  1  direction mispredicted; repair the GHR.
- ready  out  1  init sweep done; predictions valid.

Behaviour:
- Decode on inst[31:26]:
  - cond = 0x16..0x1B (beq/bne/blt/bge/bltu/bgeu, offs16 = inst[25:10]).
  - uncond = 0x14/0x15 (b/bl, offs26 = {inst[9:0], inst[25:10]}).
  - All other opcodes, including jirl: not predicted.
- Branch targets (32-bit wraparound, carry discarded):
  - cond: pc + sext({offs16, 2'b00}).
  - uncond: pc + sext({offs26, 2'b00}).
- Index: idx = pc[IDX_W+1:2] XOR zero-extended GHR when USE_GHR=1, else pc[IDX_W+1:2]. pred_idx = idx, always driven.
- Prediction when ready=1:
  - cond: pred_taken = pht[idx][1].
  - uncond: pred_taken = 1.
  - otherwise: pred_taken = 0.
  - pre_pc = pred_taken ? target : pc+4.
- When ready=0: pred_taken = 0 and pre_pc = pc+4 regardless of inst.
- The prediction path is purely combinational (0-cycle latency). State changes take effect the next cycle.
- FSM states: INIT, RUN.
  - Reset: state=INIT, init_ptr=0, GHR=0, ready=0.
  - INIT: each cycle writes INIT_CTR to pht[init_ptr] and increments init_ptr. When init_ptr = 2^IDX_W-1 the FSM moves to RUN on the next edge. Sweep takes exactly 2^IDX_W cycles; ready=1 from cycle 2^IDX_W after reset deasserts.
  - INIT ignores upd_valid and fetch_fire. GHR stays 0.
  - RUN is the terminal state. Only reset returns to INIT; reset mid-sweep restarts the sweep from 0.
- Counter update (RUN, upd_valid):
  - upd_taken: pht[upd_idx] = min(ctr+1, 3).
  - otherwise: pht[upd_idx] = max(ctr-1, 0).
- GHR update (RUN, USE_GHR=1), in priority order:
  1. upd_valid & upd_mispredict: GHR <= {upd_ghr[HIST_W-2:0], upd_taken}. The repair overrides any same-cycle speculative update. For HIST_W=1, GHR <= upd_taken.
  2. Else if fetch_fire & cond: GHR <= {GHR[HIST_W-2:0], pred_taken}.
  3. Otherwise GHR holds.
  - Uncond branches never shift the GHR.
- Simultaneous update and prediction to the same index: the prediction reads the pre-update counter. There is no bypass.

Decomposition:
- Shared package bpred_pkg:
  - opcode constants OP_BEQ..OP_BGEU, OP_B, OP_BL.
  - counter encodings SNT=0, WNT=1, WT=2, ST=3.
  - FSM state typedef {INIT, RUN}.
- Sub-module br_decode: combinational; takes pc and inst, outputs is_cond, is_uncond, target.
- Counter table, FSM and GHR live in gshare_bpred.

Test Plan:
- Reset with IDX_W=6: ready=0 for exactly 64 cycles, rises on cycle 64. A beq fetched during init gives pre_pc=pc+4, pred_taken=0.
- After init: pc=0x1C000000, beq with offs16=0x0004 predicts not-taken (INIT_CTR=1), pre_pc=0x1C000004. One upd_taken on that idx, then the same fetch gives pre_pc=0x1C000010.
- Saturation: 5 taken updates then 1 not-taken leaves ctr=2 (still taken). 5 not-taken updates leave ctr=0, and one taken gives 1 (not taken).
- b with offs26=0x3FFFFFF at pc=0x00000000: pre_pc=0xFFFFFFFC, pred_taken=1, GHR unchanged. jirl: pred_taken=0, pre_pc=pc+4.
- GHR repair: three predicted-taken cond fetches give GHR=4'b0111. Then in one cycle, upd_mispredict with upd_ghr=4'b0001, upd_taken=0 plus a fetch_fire cond: GHR=4'b0010.
- Reset asserted at sweep cycle 20: ready stays 0, and the sweep completes 64 cycles after reset release.

Source files
------------

// File: rtl/bpred_pkg.sv
// Shared definitions for the gshare branch predictor: LoongArch32 branch
// opcodes, 2-bit counter encodings and the init/run FSM state type.
package bpred_pkg;

  // Conditional branch opcodes (inst[31:26]), offs16 in inst[25:10]
  localparam logic [5:0] OP_BEQ  = 6'h16;
  localparam logic [5:0] OP_BNE  = 6'h17;
  localparam logic [5:0] OP_BLT  = 6'h18;
  localparam logic [5:0] OP_BGE  = 6'h19;
  localparam logic [5:0] OP_BLTU = 6'h1A;
  localparam logic [5:0] OP_BGEU = 6'h1B;

  // Unconditional branch opcodes, offs26 = {inst[9:0], inst[25:10]}
  localparam logic [5:0] OP_B    = 6'h14;
  localparam logic [5:0] OP_BL   = 6'h15;

  // Saturating counter encodings; the upper bit is the taken prediction
  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  // INIT sweeps the table after reset, RUN predicts and trains
  typedef enum logic {
    INIT,
    RUN
  } bpred_state_t;

endpackage

// File: rtl/gshare_bpred_br_decode.sv
// Branch decoder: classifies the fetched instruction as conditional,
// unconditional or neither, and computes its PC-relative target.
module br_decode
  import bpred_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic        is_cond_o,
  output logic        is_uncond_o,
  output logic [31:0] target_o
);

  logic [5:0]  opcode;
  logic [31:0] offs16Ext;
  logic [31:0] offs26Ext;

  // Opcode classification and target adders; the carry out of bit 31 is discarded
  always_comb begin
    opcode      = inst_i[31:26];
    offs16Ext   = {{14{inst_i[25]}}, inst_i[25:10], 2'b00};
    offs26Ext   = {{4{inst_i[9]}}, inst_i[9:0], inst_i[25:10], 2'b00};
    is_cond_o   = (opcode == OP_BEQ)  || (opcode == OP_BNE)  ||
                  (opcode == OP_BLT)  || (opcode == OP_BGE)  ||
                  (opcode == OP_BLTU) || (opcode == OP_BGEU);
    is_uncond_o = (opcode == OP_B) || (opcode == OP_BL);
    target_o    = is_uncond_o ? (pc_i + offs26Ext) : (pc_i + offs16Ext);
  end

endmodule

// File: rtl/gshare_bpred.sv
// Gshare direction/target predictor for the fetch stage. A table of 2-bit
// counters indexed by PC (optionally XORed with a speculative GHR) gives a
// combinational next-PC; EX trains the counters and repairs the GHR.
module gshare_bpred
  import bpred_pkg::*;
#(
  parameter int         IDX_W    = 6,
  parameter int         HIST_W   = 4,
  parameter bit         USE_GHR  = 1'b1,
  parameter logic [1:0] INIT_CTR = WNT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_fire,
  input  logic [31:0]       pc,
  input  logic [31:0]       inst,
  output logic [31:0]       pre_pc,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_idx,
  output logic [HIST_W-1:0] pred_ghr,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic [HIST_W-1:0] upd_ghr,
  input  logic              upd_taken,
  input  logic              upd_mispredict,
  output logic              ready
);

  localparam int DEPTH = 1 << IDX_W;

  bpred_state_t      state_q, state_d;
  logic [IDX_W-1:0]  init_ptr_q, init_ptr_d;
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [1:0]        pht_q [DEPTH];

  logic              isCond;
  logic              isUncond;
  logic [31:0]       target;
  logic [1:0]        ctrRead;
  logic [1:0]        ctrTrained;
  logic [HIST_W:0]   repairShift;
  logic [HIST_W:0]   specShift;

  br_decode u_decode (
    .pc_i        (pc),
    .inst_i      (inst),
    .is_cond_o   (isCond),
    .is_uncond_o (isUncond),
    .target_o    (target)
  );

  // Prediction path: index hash, counter read and next-PC select
  always_comb begin
    if (USE_GHR) pred_idx = pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
    else         pred_idx = pc[IDX_W+1:2];
    pred_ghr   = ghr_q;
    ready      = (state_q == RUN);
    ctrRead    = pht_q[pred_idx];
    pred_taken = ready && (isUncond || (isCond && (ctrRead >= WT)));
    pre_pc     = pred_taken ? target : (pc + 32'd4);
  end

  // Saturating increment/decrement of the counter being trained
  always_comb begin
    ctrTrained = pht_q[upd_idx];
    if (upd_taken) begin
      if (ctrTrained != ST) ctrTrained = ctrTrained + 2'd1;
    end else begin
      if (ctrTrained != SNT) ctrTrained = ctrTrained - 2'd1;
    end
  end

  // Next state: init sweep pointer, INIT->RUN handoff and GHR repair/speculation
  always_comb begin
    state_d     = state_q;
    init_ptr_d  = init_ptr_q;
    ghr_d       = ghr_q;
    repairShift = {upd_ghr, upd_taken};
    specShift   = {ghr_q, pred_taken};
    case (state_q)
      INIT: begin
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == '1) state_d = RUN;
      end
      RUN: begin
        if (USE_GHR) begin
          if (upd_valid && upd_mispredict) ghr_d = repairShift[HIST_W-1:0];
          else if (fetch_fire && isCond)   ghr_d = specShift[HIST_W-1:0];
        end
      end
      default: state_d = INIT;
    endcase
  end

  // State, sweep pointer and history registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
      ghr_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      ghr_q      <= ghr_d;
    end
  end

  // Counter table write: sweep fill during INIT, training during RUN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == INIT)  pht_q[init_ptr_q] <= INIT_CTR;
      else if (upd_valid)   pht_q[upd_idx]    <= ctrTrained;
    end
  end

endmodule

// File: tb/tb_gshare_bpred.sv
// Directed testbench for gshare_bpred with default parameters
// (IDX_W=6, HIST_W=4, USE_GHR=1, INIT_CTR=2'b01).
module tb_gshare_bpred;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_fire;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] pre_pc;
  logic        pred_taken;
  logic [5:0]  pred_idx;
  logic [3:0]  pred_ghr;
  logic        upd_valid;
  logic [5:0]  upd_idx;
  logic [3:0]  upd_ghr;
  logic        upd_taken;
  logic        upd_mispredict;
  logic        ready;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] BEQ4  = 32'h5800_1000;
  localparam logic [31:0] BFAR  = 32'h53FF_FFFF;
  localparam logic [31:0] JIRL  = 32'h4C00_0000;
  localparam logic [31:0] PCA   = 32'h1C00_0000;
  localparam logic [31:0] PCB   = 32'h1C00_0014;

  gshare_bpred dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_fire     (fetch_fire),
    .pc             (pc),
    .inst           (inst),
    .pre_pc         (pre_pc),
    .pred_taken     (pred_taken),
    .pred_idx       (pred_idx),
    .pred_ghr       (pred_ghr),
    .upd_valid      (upd_valid),
    .upd_idx        (upd_idx),
    .upd_ghr        (upd_ghr),
    .upd_taken      (upd_taken),
    .upd_mispredict (upd_mispredict),
    .ready          (ready)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // One clock edge, then step past it so outputs are sampled away from the edge
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a fetch and let the combinational path settle
  task automatic applyStimulus(input logic [31:0] newPc, input logic [31:0] newInst,
                               input logic fire);
    pc         = newPc;
    inst       = newInst;
    fetch_fire = fire;
    #1;
  endtask

  // Drive (or clear) the EX-stage training port
  task automatic applyUpdate(input logic valid, input logic [5:0] idx, input logic taken,
                             input logic mispredict, input logic [3:0] ghr);
    upd_valid      = valid;
    upd_idx        = idx;
    upd_taken      = taken;
    upd_mispredict = mispredict;
    upd_ghr        = ghr;
  endtask

  // Apply n identical training updates, one per cycle
  task automatic trainCounter(input logic [5:0] idx, input logic taken, input int n);
    for (int i = 0; i < n; i++) begin
      applyUpdate(1'b1, idx, taken, 1'b0, 4'h0);
      tick();
    end
    applyUpdate(1'b0, 6'd0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, actual, expected);
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(PCA, BEQ4, 1'b0);
    applyUpdate(1'b0, 6'd0, 1'b0, 1'b0, 4'h0);
    tick(2);
    checkOutput("reset_ready", {31'd0, ready}, 32'd0);
    checkOutput("reset_ghr", {28'd0, pred_ghr}, 32'd0);

    // First sweep: 64 edges after release, ready rises exactly on the 64th
    reset = 1'b0;
    tick(63);
    checkOutput("init_ready_low", {31'd0, ready}, 32'd0);
    checkOutput("init_beq_taken", {31'd0, pred_taken}, 32'd0);
    checkOutput("init_beq_prepc", pre_pc, 32'h1C00_0004);
    tick();
    checkOutput("init_ready_high", {31'd0, ready}, 32'd1);

    // Fresh counter (weakly not-taken), then one taken update flips it
    applyStimulus(PCA, BEQ4, 1'b0);
    checkOutput("beq_idx", {26'd0, pred_idx}, 32'd0);
    checkOutput("beq_nt_taken", {31'd0, pred_taken}, 32'd0);
    checkOutput("beq_nt_prepc", pre_pc, 32'h1C00_0004);
    trainCounter(6'd0, 1'b1, 1);
    checkOutput("beq_t_taken", {31'd0, pred_taken}, 32'd1);
    checkOutput("beq_t_prepc", pre_pc, 32'h1C00_0010);

    // Saturation on index 5: 1->3 (sat) ->2 taken; then down to 0 (sat) ->1 not taken
    applyStimulus(PCB, BEQ4, 1'b0);
    checkOutput("sat_idx", {26'd0, pred_idx}, 32'd5);
    trainCounter(6'd5, 1'b1, 5);
    trainCounter(6'd5, 1'b0, 1);
    checkOutput("sat_hi_taken", {31'd0, pred_taken}, 32'd1);
    checkOutput("sat_hi_prepc", pre_pc, 32'h1C00_0024);
    trainCounter(6'd5, 1'b0, 5);
    checkOutput("sat_lo_taken", {31'd0, pred_taken}, 32'd0);
    trainCounter(6'd5, 1'b1, 1);
    checkOutput("sat_lo1_taken", {31'd0, pred_taken}, 32'd0);
    checkOutput("sat_lo1_prepc", pre_pc, 32'h1C00_0018);

    // Unconditional branch wraps below zero and never shifts the GHR
    applyStimulus(32'h0000_0000, BFAR, 1'b1);
    checkOutput("b_taken", {31'd0, pred_taken}, 32'd1);
    checkOutput("b_prepc", pre_pc, 32'hFFFF_FFFC);
    tick();
    checkOutput("b_ghr", {28'd0, pred_ghr}, 32'd0);

    // jirl is never predicted
    applyStimulus(32'h1C00_0100, JIRL, 1'b0);
    checkOutput("jirl_taken", {31'd0, pred_taken}, 32'd0);
    checkOutput("jirl_prepc", pre_pc, 32'h1C00_0104);

    // Prime indices 1 and 3 so the GHR walk 0->1->3 stays predicted-taken
    trainCounter(6'd1, 1'b1, 1);
    trainCounter(6'd3, 1'b1, 1);
    applyStimulus(PCA, BEQ4, 1'b1);
    checkOutput("ghr_f1_taken", {31'd0, pred_taken}, 32'd1);
    tick();
    checkOutput("ghr_f1", {28'd0, pred_ghr}, 32'h1);
    checkOutput("ghr_f2_idx", {26'd0, pred_idx}, 32'd1);
    checkOutput("ghr_f2_taken", {31'd0, pred_taken}, 32'd1);
    tick();
    checkOutput("ghr_f2", {28'd0, pred_ghr}, 32'h3);
    checkOutput("ghr_f3_taken", {31'd0, pred_taken}, 32'd1);
    tick();
    checkOutput("ghr_f3", {28'd0, pred_ghr}, 32'h7);

    // Repair wins over the same-cycle speculative shift
    applyUpdate(1'b1, 6'd10, 1'b0, 1'b1, 4'b0001);
    tick();
    applyUpdate(1'b0, 6'd0, 1'b0, 1'b0, 4'h0);
    applyStimulus(PCA, BEQ4, 1'b0);
    checkOutput("repair_ghr", {28'd0, pred_ghr}, 32'h2);
    checkOutput("repair_idx", {26'd0, pred_idx}, 32'd2);

    // Reset at sweep cycle 20 restarts the sweep; INIT ignores training and fetches
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick(20);
    checkOutput("mid_ready_low", {31'd0, ready}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(PCA, BEQ4, 1'b1);
    applyUpdate(1'b1, 6'd0, 1'b1, 1'b1, 4'hF);
    tick(63);
    applyUpdate(1'b0, 6'd0, 1'b0, 1'b0, 4'h0);
    fetch_fire = 1'b0;
    #1;
    checkOutput("resweep_ready_low", {31'd0, ready}, 32'd0);
    checkOutput("resweep_ghr", {28'd0, pred_ghr}, 32'd0);
    tick();
    checkOutput("resweep_ready_high", {31'd0, ready}, 32'd1);
    checkOutput("resweep_beq_taken", {31'd0, pred_taken}, 32'd0);
    checkOutput("resweep_beq_prepc", pre_pc, 32'h1C00_0004);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
